lcd_text_engine: RTL and testbench
==================================

Name: lcd_text_engine

Overview:
- Parametrised HD44780 text-mode controller that replaces the fixed init-only sequencer.
- Holds a ROWS x COLS character buffer written by the host.
- Runs the power-up/init command list with per-command execution delays.
- Refreshes only when the buffer is dirty, emitting command/data bytes over a valid/ready handshake to the existing IIC byte writer (PCF8574 path).

Parameters:
CLK_HZ, 50000000, system clock frequency; delays are derived as CLK_HZ/1000000*US cycles
ROWS, 2, display lines, 1..4
COLS, 16, characters per line, 8..20
POWERUP_US, 15000, wait after reset before the first byte
CMD_US, 50, gap after each ordinary command or data byte
CLEAR_US, 2000, gap after a 0x01 or 0x02 command

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  buffer write strobe, single cycle
wr_row  in  2  target row
wr_col  in  5  target column
wr_char  in  8  character code
clear  in  1  pulse: fill buffer with 0x20
byte_data  out  8  byte to LCD
byte_is_data  out  1  1 = data (RS=1), 0 = command
byte_valid  out  1  byte_data/byte_is_data valid
byte_ready  in  1  downstream writer accepts the byte this cycle
init_done  out  1  init list complete
busy  out  1  high during POWER_WAIT, INIT, REFRESH, or a pending gap

Behaviour:
- One clock and a synchronous active-high reset: reset is sampled only on the rising edge of clk, and rst=1 forces the reset state.
- Reset values:
  - byte_valid=0, byte_data=0x00, byte_is_data=0, init_done=0, busy=1.
  - All buffer cells = 0x20, dirty=1, state=POWER_WAIT.
- Reset mid-operation: the next edge drops byte_valid regardless of byte_ready, and the init sequence restarts from POWER_WAIT.
- Handshake:
  - A transfer occurs on any edge where byte_valid and byte_ready are both 1.
  - While byte_valid=1 and byte_ready=0, byte_data and byte_is_data stay stable.
  - byte_valid never drops without a transfer, except on reset.
- Gap timing:
  - After the transfer edge at cycle t, byte_valid=0 until cycle t+GAP, where it reasserts with the next byte if one is due.
  - GAP = CLEAR_CYC after command 0x01 or 0x02; GAP = CMD_CYC otherwise.
- FSM states: POWER_WAIT -> INIT -> IDLE <-> REFRESH.
  - POWER_WAIT: counts POWER_CYC cycles. The first byte_valid is asserted POWER_CYC cycles after the first cycle with rst=0.
  - INIT: issues commands 0x33, 0x32, FSET, 0x0C, 0x06, 0x01 in order, with FSET = 0x28 if ROWS>1, else 0x20. init_done rises in the cycle the gap after 0x01 expires, then the FSM moves to IDLE.
  - IDLE: if dirty=1, go to REFRESH and clear dirty in the same cycle.
  - REFRESH: for r = 0..ROWS-1, issue command 0x80|ADDR(r), then COLS data bytes buf[r][0..COLS-1].
    - ADDR(0)=0x00, ADDR(1)=0x40, ADDR(2)=COLS, ADDR(3)=0x40+COLS.
    - After the last byte's gap, return to IDLE.
  - busy=0 only in IDLE with dirty=0.
- Buffer writes:
  - Accepted in any state with no back-pressure; the cell updates on the edge where wr_en=1.
  - Each accepted write sets dirty=1.
  - Writes with wr_row>=ROWS or wr_col>=COLS are ignored and do not set dirty.
  - A write during REFRESH updates the buffer. The current pass may or may not show the new value, but dirty=1 guarantees a following full pass.
- clear:
  - Fills every cell with 0x20 in one cycle and sets dirty=1.
  - clear and wr_en in the same cycle: clear wins and the write is dropped.
- Data bytes are read from the buffer in the cycle byte_valid rises, then held until the transfer.
- Counters are sized for the largest delay. At CLK_HZ=50 MHz, POWER_CYC = 750000, which needs 20 bits.

Test Plan:
1. Init timing. CLK_HZ=1000000, byte_ready tied 1, rst released at cycle 0. Required response:
   - First byte_valid at cycle 15000, byte 0x33, byte_is_data=0.
   - Then 0x32, 0x28, 0x0C, 0x06 at 50-cycle spacing, then 0x01.
   - init_done rises 2000 cycles after the 0x01 transfer.
   - An automatic refresh follows: 0x80, 16x 0x20, 0xC0, 16x 0x20.
2. Single character. After idle, wr_en with row=1, col=3, char=0x41. Required response:
   - One pass: 0x80, 16x 0x20, 0xC0, 0x20x3, 0x41, 0x20x12.
   - busy=0 afterwards.
3. Back-pressure. byte_ready held 0 for 10 cycles while byte_valid=1 with byte 0xC0. Required response:
   - byte_valid and byte_data stay 1/0xC0.
   - Transfer happens on the first cycle byte_ready=1.
   - The next byte appears exactly 50 cycles later.
4. Illegal and simultaneous writes:
   - wr_en with row=2 (ROWS=2) in IDLE: no byte_valid and busy stays 0.
   - clear and wr_en (row0, col0, 0x41) in the same cycle: the pass sends row0 col0 = 0x20.
5. 4x20 configuration. ROWS=4, COLS=20, FSET=0x28. Required response:
   - Row address commands are 0x80, 0xC0, 0x94, 0xD4, each followed by 20 data bytes.
6. Reset mid-refresh. rst=1 for 1 cycle while byte_valid=1. Required response:
   - Next cycle byte_valid=0 and init_done=0.
   - After release, 0x33 reappears at exactly 15000 cycles.

Source files
------------

// File: rtl/lcd_text_engine.sv
// lcd_text_engine: HD44780 text-mode controller.
// Holds a ROWS x COLS character buffer, runs the power-up/init command list,
// and streams a full refresh (row address command + row data) whenever the
// buffer has been modified. Bytes leave over a valid/ready handshake; after
// each accepted byte a gap is observed before the next one is offered.
module lcd_text_engine #(
  parameter int CLK_HZ     = 50000000,
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int POWERUP_US = 15000,
  parameter int CMD_US     = 50,
  parameter int CLEAR_US   = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [4:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic       clear,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       init_done,
  output logic       busy
);

  localparam int CYC_PER_US = CLK_HZ / 1000000;
  localparam int POWER_CYC  = CYC_PER_US * POWERUP_US;
  localparam int CMD_CYC    = CYC_PER_US * CMD_US;
  localparam int CLEAR_CYC  = CYC_PER_US * CLEAR_US;
  localparam int GAP_MAX    = (CLEAR_CYC > CMD_CYC) ? CLEAR_CYC : CMD_CYC;
  localparam int MAX_CYC    = (POWER_CYC > GAP_MAX) ? POWER_CYC : GAP_MAX;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);

  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] FSET     = (ROWS > 1) ? 8'h28 : 8'h20;
  localparam logic [2:0] INIT_LEN = 3'd6;
  localparam logic [2:0] ROWS_L   = 3'(ROWS);
  localparam logic [4:0] COLS_L   = 5'(COLS);

  typedef enum logic [1:0] {POWER_WAIT, INIT, IDLE, REFRESH} state_e;

  // Init command list in issue order.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h33;
      3'd1:    init_cmd = 8'h32;
      3'd2:    init_cmd = FSET;
      3'd3:    init_cmd = 8'h0C;
      3'd4:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  // Set-DDRAM-address command for the start of a display row.
  function automatic logic [7:0] row_addr(input logic [2:0] r);
    case (r)
      3'd0:    row_addr = 8'h80;
      3'd1:    row_addr = 8'hC0;
      3'd2:    row_addr = 8'h80 + 8'(COLS);
      default: row_addr = 8'hC0 + 8'(COLS);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             is_data_q, is_data_d;
  logic             init_done_q, init_done_d;
  logic             busy_q, busy_d;
  logic             dirty_q, dirty_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic [2:0]       row_q, row_d;
  logic [4:0]       col_q, col_d;
  logic [7:0]       cells_q [ROWS][COLS];
  logic [7:0]       cells_d [ROWS][COLS];

  logic             wr_ok_s;
  logic             expire_s;
  logic             clr_dirty_s;
  logic [7:0]       cell_s;
  logic [CNT_W-1:0] gap_load_s;

  assign wr_ok_s = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

  // Clear/home commands need the long execution gap; everything else the short one.
  assign gap_load_s = (!is_data_q && ((data_q == 8'h01) || (data_q == 8'h02)))
                      ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(CMD_CYC - 1);

  // Buffer cell addressed by the refresh pointer (col_q=0 is the row address slot).
  always_comb begin
    cell_s = SPACE;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cell_s = ((3'(r) == row_q) && (5'(c + 1) == col_q)) ? cells_q[r][c] : cell_s;
      end
    end
  end

  // Host side buffer update: clear fills with spaces and overrides a same-cycle write.
  always_comb begin
    cells_d = cells_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cells_d[r][c] = clear ? SPACE :
                        ((wr_ok_s && (2'(r) == wr_row) && (5'(c) == wr_col)) ? wr_char : cells_q[r][c]);
      end
    end
  end

  // Sequencer: handshake, gap countdown, and next-byte selection per state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    is_data_d   = is_data_q;
    init_done_d = init_done_q;
    init_idx_d  = init_idx_q;
    row_d       = row_q;
    col_d       = col_q;
    expire_s    = 1'b0;
    clr_dirty_s = 1'b0;

    if (valid_q) begin
      if (byte_ready) begin
        valid_d = 1'b0;
        cnt_d   = gap_load_s;
        if (state_q == INIT) begin
          init_idx_d = init_idx_q + 3'd1;
        end else if (col_q == COLS_L) begin
          col_d = 5'd0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 5'd1;
        end
      end else begin
        valid_d = 1'b1;
      end
    end else if (state_q == IDLE) begin
      if (dirty_q) begin
        clr_dirty_s = 1'b1;
        state_d     = REFRESH;
        row_d       = 3'd0;
        col_d       = 5'd0;
        valid_d     = 1'b1;
        data_d      = row_addr(3'd0);
        is_data_d   = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      expire_s = 1'b1;
    end

    if (expire_s) begin
      case (state_q)
        POWER_WAIT: begin
          state_d    = INIT;
          init_idx_d = 3'd0;
          valid_d    = 1'b1;
          data_d     = init_cmd(3'd0);
          is_data_d  = 1'b0;
        end
        INIT: begin
          if (init_idx_q == INIT_LEN) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            valid_d   = 1'b1;
            data_d    = init_cmd(init_idx_q);
            is_data_d = 1'b0;
          end
        end
        REFRESH: begin
          if (row_q == ROWS_L) begin
            state_d = IDLE;
          end else if (col_q == 5'd0) begin
            valid_d   = 1'b1;
            data_d    = row_addr(row_q);
            is_data_d = 1'b0;
          end else begin
            valid_d   = 1'b1;
            data_d    = cell_s;
            is_data_d = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      init_done_d = init_done_q;
    end
  end

  // A host write or clear always re-arms the refresh, even in the cycle IDLE consumes the flag.
  always_comb begin
    if (clear || wr_ok_s) begin
      dirty_d = 1'b1;
    end else if (clr_dirty_s) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
    busy_d = !((state_d == IDLE) && !dirty_d);
  end

  // State registers with synchronous reset back to the power-up wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= POWER_WAIT;
      cnt_q       <= CNT_W'(POWER_CYC);
      valid_q     <= 1'b0;
      data_q      <= 8'h00;
      is_data_q   <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      dirty_q     <= 1'b1;
      init_idx_q  <= 3'd0;
      row_q       <= 3'd0;
      col_q       <= 5'd0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          cells_q[r][c] <= SPACE;
        end
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      is_data_q   <= is_data_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      dirty_q     <= dirty_d;
      init_idx_q  <= init_idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cells_q     <= cells_d;
    end
  end

  assign byte_data    = data_q;
  assign byte_is_data = is_data_q;
  assign byte_valid   = valid_q;
  assign init_done    = init_done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_text_engine.sv
// tb_lcd_text_engine: directed + randomized bench for lcd_text_engine.
// A 2x16 instance carries the main sequence; a 4x20 instance runs its init
// and first refresh alongside. Expected byte streams come from a character
// model of the buffer and the controller's documented byte ordering.
module tb_lcd_text_engine;

  localparam int P = 15000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic       wr_en = 1'b0, clear = 1'b0, byte_ready = 1'b1;
  logic [1:0] wr_row = 2'd0;
  logic [4:0] wr_col = 5'd0;
  logic [7:0] wr_char = 8'h00;
  logic [7:0] byte_data;
  logic       byte_is_data, byte_valid, init_done, busy;

  logic       wr_en4 = 1'b0, clear4 = 1'b0, byte_ready4 = 1'b1;
  logic [1:0] wr_row4 = 2'd0;
  logic [4:0] wr_col4 = 5'd0;
  logic [7:0] wr_char4 = 8'h00;
  logic [7:0] byte_data4;
  logic       byte_is_data4, byte_valid4, init_done4, busy4;

  logic [7:0] mbuf  [2][16];
  logic [7:0] mbuf4 [4][20];
  logic [8:0] q[$];
  logic [8:0] q4[$];
  int         xc[$];
  int         rd = 0;
  logic [7:0] init_list [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

  lcd_text_engine #(.CLK_HZ(1000000)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_char(wr_char), .clear(clear), .byte_data(byte_data),
    .byte_is_data(byte_is_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .init_done(init_done), .busy(busy));

  lcd_text_engine #(.CLK_HZ(1000000), .ROWS(4), .COLS(20)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_row(wr_row4), .wr_col(wr_col4),
    .wr_char(wr_char4), .clear(clear4), .byte_data(byte_data4),
    .byte_is_data(byte_is_data4), .byte_valid(byte_valid4), .byte_ready(byte_ready4),
    .init_done(init_done4), .busy(busy4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor: a byte moves whenever valid and ready meet outside reset.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      q.push_back({byte_is_data, byte_data});
      xc.push_back(cyc);
    end
    if (!rst && byte_valid4 && byte_ready4) begin
      q4.push_back({byte_is_data4, byte_data4});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] addr_cmd(input int r, input int cols);
    case (r)
      0:       return 8'h80;
      1:       return 8'hC0;
      2:       return 8'(8'h80 + cols);
      default: return 8'(8'hC0 + cols);
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++) for (int c = 0; c < 16; c++) mbuf[r][c] = 8'h20;
  endtask

  task automatic expect_byte(input string tag, input logic [8:0] exp);
    int n = 0;
    while (q.size() <= rd && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() <= rd) begin
      chk({tag, "_timeout"}, q.size(), rd + 1);
    end else begin
      chk(tag, q[rd], exp);
      rd++;
    end
  endtask

  task automatic check_pass(input string tag);
    for (int r = 0; r < 2; r++) begin
      expect_byte({tag, "_addr"}, {1'b0, addr_cmd(r, 16)});
      for (int c = 0; c < 16; c++) expect_byte({tag, "_data"}, {1'b1, mbuf[r][c]});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic do_write(input logic [1:0] r, input logic [4:0] c, input logic [7:0] ch,
                          input logic clr, output logic legal);
    step();
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_char = ch; clear = clr;
    legal = (r < 2'd2) && (c < 5'd16);
    if (clr) model_reset();
    else if (legal) mbuf[int'(r)][int'(c)] = ch;
    step();
    wr_en = 1'b0; clear = 1'b0;
  endtask

  task automatic check_init(input string tag, input int t0);
    int bi;
    while (cyc < t0 + P - 1) @(negedge clk);
    chk({tag, "_pre_valid"}, byte_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_first_valid"}, byte_valid, 1'b1);
    chk({tag, "_first_byte"}, {byte_is_data, byte_data}, 9'h033);
    bi = rd;
    for (int i = 0; i < 6; i++) expect_byte({tag, "_cmd"}, {1'b0, init_list[i]});
    if (rd == bi + 6) begin
      chk({tag, "_first_xfer_cyc"}, xc[bi], t0 + P);
      for (int i = 0; i < 5; i++) chk({tag, "_cmd_spacing"}, xc[bi+i+1] - xc[bi+i], 50);
      while (cyc < xc[bi+5] + 1999) @(negedge clk);
      chk({tag, "_init_done_early"}, init_done, 1'b0);
      @(negedge clk);
      chk({tag, "_init_done_rise"}, init_done, 1'b1);
    end
  endtask

  initial begin
    int t0, base, v, viol, n, extra;
    logic lg;
    logic [1:0] r;
    logic [4:0] c;

    model_reset();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 20; j++) mbuf4[i][j] = 8'h20;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", byte_valid, 1'b0);
    chk("rst_data", byte_data, 8'h00);
    chk("rst_is_data", byte_is_data, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_busy", busy, 1'b1);
    step();
    rst = 1'b0;
    t0 = cyc;

    // 4x20 instance: random writes accepted during the power-up wait, one off-screen
    for (int i = 0; i < 6; i++) begin
      step();
      r = 2'($urandom_range(0, 3));
      c = (i == 5) ? 5'd20 : 5'($urandom_range(0, 19));
      wr_en4 = 1'b1; wr_row4 = r; wr_col4 = c; wr_char4 = 8'($urandom_range(33, 126));
      if (c < 5'd20) mbuf4[int'(r)][int'(c)] = wr_char4;
    end
    step();
    wr_en4 = 1'b0;

    // 1. Init timing and automatic first refresh
    check_init("init", t0);
    check_pass("pass1");

    // 2. Single character
    wait_idle("idle_after_pass1");
    do_write(2'd1, 5'd3, 8'h41, 1'b0, lg);
    check_pass("single_char");
    wait_idle("idle_after_single");

    // 4x20 stream: init list then four rows with their address commands
    n = 0;
    while (q4.size() < 90 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("rows4_count", (q4.size() >= 90), 1'b1);
    if (q4.size() >= 90) begin
      for (int i = 0; i < 6; i++) chk("rows4_init", q4[i], {1'b0, init_list[i]});
      for (int i = 0; i < 4; i++) begin
        chk("rows4_addr", q4[6 + i*21], {1'b0, addr_cmd(i, 20)});
        for (int j = 0; j < 20; j++) chk("rows4_data", q4[7 + i*21 + j], {1'b1, mbuf4[i][j]});
      end
    end

    // 3. Back-pressure on the second row address command
    base = rd;
    do_write(2'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 8'($urandom_range(33, 126)), 1'b0, lg);
    n = 0;
    while (q.size() < base + 17 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    step();
    byte_ready = 1'b0;
    n = 0;
    while (byte_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    v = cyc;
    chk("bp_valid", byte_valid, 1'b1);
    chk("bp_byte", {byte_is_data, byte_data}, 9'h0C0);
    viol = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (!(byte_valid === 1'b1 && byte_data === 8'hC0 && byte_is_data === 1'b0)) viol++;
    end
    chk("bp_stable", viol, 0);
    step();
    byte_ready = 1'b1;
    check_pass("bp_pass");
    if (rd >= base + 19) begin
      chk("bp_xfer_cyc", xc[base+17], v + 10);
      chk("bp_next_gap", xc[base+18] - xc[base+17], 50);
    end

    // 4. Off-screen writes, then clear colliding with a write
    wait_idle("idle_before_illegal");
    do_write(2'd2, 5'd5, 8'h55, 1'b0, lg);
    do_write(2'd0, 5'd16, 8'h56, 1'b0, lg);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (byte_valid !== 1'b0 || busy !== 1'b0) viol++;
    end
    chk("illegal_no_activity", viol, 0);
    do_write(2'd0, 5'd0, 8'h41, 1'b1, lg);
    check_pass("clear_wins");

    // Randomized bursts: writes landing while a pass is stalled force a second pass
    for (int it = 0; it < 3; it++) begin
      wait_idle("idle_rand");
      step();
      byte_ready = 1'b0;
      do_write(2'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 8'($urandom_range(33, 126)), 1'b0, lg);
      repeat (3) step();
      extra = 0;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        do_write(2'($urandom_range(0, 3)), 5'($urandom_range(0, 17)), 8'($urandom_range(33, 126)), 1'b0, lg);
        if (lg) extra = 1;
      end
      step();
      byte_ready = 1'b1;
      check_pass("rand_pass");
      if (extra != 0) check_pass("rand_repass");
    end

    // 6. Reset while a byte is being offered
    wait_idle("idle_before_reset");
    step();
    byte_ready = 1'b0;
    do_write(2'd0, 5'd5, 8'h5A, 1'b0, lg);
    n = 0;
    while (byte_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_valid", byte_valid, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    byte_ready = 1'b1;
    t0 = cyc;
    model_reset();
    @(negedge clk);
    chk("mid_rst_valid", byte_valid, 1'b0);
    chk("mid_rst_init_done", init_done, 1'b0);
    chk("mid_rst_busy", busy, 1'b1);
    rd = q.size();
    check_init("reinit", t0);
    check_pass("reinit_pass");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
